snoop_bus_arbiter: RTL and testbench

- Arbiter and sequencer for the shared snooping bus between NUM_CACHES cache controllers in the MSI coherence system.
- Picks one pending miss or invalidate request per transaction, round-robin.
- Broadcasts the request on the bus and collects the snoopers' write-back/abort responses.
- Then either waits for the owner's write-back or runs a fixed-latency memory access, and signals completion to the winning cache.

---
 rtl/snoop_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter for the MSI cache system. It picks one pending cache
// request round-robin, broadcasts it, gathers snoop write-back responses,
// then waits for the owner's write-back or runs a fixed-latency memory
// access, and finally pulses done to the winning cache.
module snoop_bus_arbiter #(
  parameter int NUM_CACHES = 4,
  parameter int ADDR_W     = 8,
  parameter int MEM_LAT    = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_CACHES-1:0]        req,
  input  logic [2*NUM_CACHES-1:0]      req_op,
  input  logic [ADDR_W*NUM_CACHES-1:0] req_addr,
  input  logic [NUM_CACHES-1:0]        snoop_wb,
  input  logic                         wb_done,
  output logic [NUM_CACHES-1:0]        grant,
  output logic                         bus_valid,
  output logic [1:0]                   bus_op,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic                         mem_req,
  output logic [NUM_CACHES-1:0]        done
);

  localparam int IDX_W = $clog2(NUM_CACHES);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    BROADCAST,
    SNOOP,
    WRITEBACK,
    MEMORY,
    COMPLETE
  } state_t;

  state_t              state_reg, state_next;
  logic [NUM_CACHES-1:0] grant_reg, grant_next;
  logic [1:0]          op_reg, op_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [IDX_W-1:0]    owner_reg, owner_next;
  logic [IDX_W-1:0]    last_reg, last_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    cand_idx;
  logic                snoop_hit;

  // Round-robin search: first requester after the last winner, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_CACHES; k++) begin
      cand_idx = IDX_W'((int'(last_reg) + k) % NUM_CACHES);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // A write-back from any other cache aborts the memory access; the owner's own flag is ignored.
  assign snoop_hit = |(snoop_wb & ~grant_reg);

  // Next-state and datapath latch decisions for the bus transaction sequencer.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    op_next    = op_reg;
    addr_next  = addr_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_next = NUM_CACHES'(1) << win_idx;
          op_next    = req_op[2*win_idx +: 2];
          addr_next  = req_addr[ADDR_W*win_idx +: ADDR_W];
          owner_next = win_idx;
          state_next = BROADCAST;
        end
      end
      BROADCAST: state_next = SNOOP;
      SNOOP: begin
        if (op_reg[1]) begin
          // Invalidate (and the reserved op) needs no data movement.
          state_next = COMPLETE;
        end else if (snoop_hit) begin
          state_next = WRITEBACK;
        end else begin
          state_next = MEMORY;
          cnt_next   = CNT_W'(MEM_LAT - 1);
        end
      end
      WRITEBACK: begin
        if (wb_done) state_next = COMPLETE;
      end
      MEMORY: begin
        if (cnt_reg == '0) state_next = COMPLETE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      COMPLETE: begin
        grant_next = '0;
        last_next  = owner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and latched transaction registers; reset puts cache 0 first in line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      op_reg    <= '0;
      addr_reg  <= '0;
      owner_reg <= '0;
      last_reg  <= IDX_W'(NUM_CACHES - 1);
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign grant     = grant_reg;
  assign bus_op    = op_reg;
  assign bus_addr  = addr_reg;
  assign bus_valid = (state_reg == BROADCAST);
  assign mem_req   = (state_reg == MEMORY);

  // Completion pulse goes only to the current owner.
  generate
    for (genvar gi = 0; gi < NUM_CACHES; gi++) begin : g_done
      assign done[gi] = grant_reg[gi] && (state_reg == COMPLETE);
    end
  endgenerate

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Scoreboard bench for snoop_bus_arbiter: stimulus pushes expected
// transactions, a monitor checks each one when done pulses.
module tb_snoop_bus_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int ML = 2;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_op;
  logic [AW*N-1:0] req_addr;
  logic [N-1:0]    snoop_wb;
  logic            wb_done;
  logic [N-1:0]    grant;
  logic            bus_valid;
  logic [1:0]      bus_op;
  logic [AW-1:0]   bus_addr;
  logic            mem_req;
  logic [N-1:0]    done;

  snoop_bus_arbiter #(.NUM_CACHES(N), .ADDR_W(AW), .MEM_LAT(ML)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_op(req_op),
    .req_addr(req_addr), .snoop_wb(snoop_wb), .wb_done(wb_done),
    .grant(grant), .bus_valid(bus_valid), .bus_op(bus_op),
    .bus_addr(bus_addr), .mem_req(mem_req), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0]  grant;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    int            lat;
    int            mem;
    int            gap;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  int n_done = 0;
  int target = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input logic [N-1:0] g, input logic [1:0] op, input logic [AW-1:0] addr,
                      input int lat, input int mem, input int gap);
    exp_t t;
    t.grant = g; t.op = op; t.addr = addr; t.lat = lat; t.mem = mem; t.gap = gap;
    exp_q.push_back(t);
  endtask

  task automatic wait_done();
    int budget;
    target++;
    budget = 0;
    while (n_done < target && budget < 100) begin
      @(negedge clock); #1;
      budget++;
    end
    if (n_done < target) chk("done_timeout", n_done, target);
  endtask

  task automatic wait_bv();
    int budget;
    budget = 0;
    do begin
      @(negedge clock); #1;
      budget++;
    end while (!bus_valid && budget < 100);
    if (!bus_valid) chk("bus_valid_timeout", 0, 1);
  endtask

  // Monitor: snapshot at the broadcast, compare against the scoreboard at done.
  initial begin : monitor
    int cv, mem_cnt, last_done;
    logic unstable, active;
    logic [N-1:0] s_grant;
    logic [1:0] s_op;
    logic [AW-1:0] s_addr;
    exp_t e;
    cv = 0; mem_cnt = 0; last_done = -100; unstable = 0; active = 0;
    s_grant = '0; s_op = '0; s_addr = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        active = 0;
      end else begin
        if (bus_valid) begin
          chk("grant_onehot", $countones(grant), 1);
          cv = cyc; s_grant = grant; s_op = bus_op; s_addr = bus_addr;
          mem_cnt = 0; unstable = 0; active = 1;
        end else if (active && (grant !== s_grant || bus_op !== s_op || bus_addr !== s_addr)) begin
          unstable = 1;
        end
        if (mem_req) mem_cnt++;
        if (done != '0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", done, 0);
          end else begin
            e = exp_q.pop_front();
            $display("txn done=%b grant=%b op=%b addr=%h lat=%0d mem=%0d", done, s_grant, s_op, s_addr, cyc - cv, mem_cnt);
            chk("done", done, e.grant);
            chk("grant", s_grant, e.grant);
            chk("bus_op", s_op, e.op);
            chk("bus_addr", s_addr, e.addr);
            chk("latency", cyc - cv, e.lat);
            chk("mem_cycles", mem_cnt, e.mem);
            chk("stable", unstable, 0);
            if (e.gap != 0) chk("gap", cv - last_done, e.gap);
          end
          last_done = cyc;
          active = 0;
          n_done++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req = '0; req_op = '0; req_addr = '0; snoop_wb = '0; wb_done = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_grant", grant, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_bus_op", bus_op, 0);
    chk("rst_bus_addr", bus_addr, 0);
    reset_n = 1'b1;

    // 1: read miss, memory path
    req_op[1:0] = 2'b00; req_addr[7:0] = 8'h3C;
    push(4'b0001, 2'b00, 8'h3C, 4, 2, 0);
    req = 4'b0001;
    wait_done();
    req = '0;

    // 2: write miss with another cache writing back
    req_op[3:2] = 2'b01; req_addr[15:8] = 8'hA5; snoop_wb = 4'b0100;
    push(4'b0010, 2'b01, 8'hA5, 6, 0, 0);
    req = 4'b0010;
    wait_bv();
    repeat (5) @(negedge clock);
    wb_done = 1'b1;
    @(negedge clock); #1;
    wb_done = 1'b0;
    wait_done();
    req = '0; snoop_wb = '0;

    // 3: invalidate ignores snoop responses
    req_op[7:6] = 2'b10; req_addr[31:24] = 8'hC3; snoop_wb = 4'b1111;
    push(4'b1000, 2'b10, 8'hC3, 2, 0, 0);
    req = 4'b1000;
    wait_done();
    req = '0; snoop_wb = '0;

    // 4: all four requesting, round-robin order with one idle cycle between
    req_op = 8'h00; req_addr = 32'h43_32_21_10;
    push(4'b0001, 2'b00, 8'h10, 4, 2, 0);
    push(4'b0010, 2'b00, 8'h21, 4, 2, 2);
    push(4'b0100, 2'b00, 8'h32, 4, 2, 2);
    push(4'b1000, 2'b00, 8'h43, 4, 2, 2);
    push(4'b0001, 2'b00, 8'h10, 4, 2, 2);
    req = 4'b1111;
    repeat (5) wait_done();
    req = '0;

    // 5: owner's own snoop_wb is ignored
    req_op[1:0] = 2'b00; req_addr[7:0] = 8'h5A; snoop_wb = 4'b0001;
    push(4'b0001, 2'b00, 8'h5A, 4, 2, 0);
    req = 4'b0001;
    wait_done();
    req = '0; snoop_wb = '0;

    // 6: reset during MEMORY aborts the transaction
    req_addr[7:0] = 8'h66;
    req = 4'b0001;
    wait_bv();
    repeat (2) @(negedge clock);
    chk("mem_before_reset", mem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_grant", grant, 0);
    chk("abort_bus_valid", bus_valid, 0);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_done", done, 0);
    chk("abort_bus_op", bus_op, 0);
    chk("abort_bus_addr", bus_addr, 0);
    req_op[5:4] = 2'b01; req_addr[23:16] = 8'h77;
    req = 4'b0100;
    @(negedge clock);
    reset_n = 1'b1;
    push(4'b0100, 2'b01, 8'h77, 4, 2, 0);
    wait_done();
    req = '0;

    // Pointer restart: without reset cache 3 would win after cache 2
    @(negedge clock);
    reset_n = 1'b0;
    req_op[1:0] = 2'b01; req_addr[7:0] = 8'h11;
    req_op[7:6] = 2'b00; req_addr[31:24] = 8'h99;
    req = 4'b1001;
    @(negedge clock);
    push(4'b0001, 2'b01, 8'h11, 4, 2, 0);
    push(4'b1000, 2'b00, 8'h99, 4, 2, 2);
    reset_n = 1'b1;
    wait_done();
    wait_done();
    req = '0;

    repeat (5) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
